// File: rtl/jtframe_db15_scan.sv
// Periodic scanner for a 32-bit 74x165 button chain behind a DB15 joystick port.
// Loads the chain, shifts 32 bits in, then publishes both player words at once.
module jtframe_db15_scan #(
    parameter int CLKDIV      = 8,
    parameter int SCAN_PERIOD = 48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_LOAD  = 2'd1;
    localparam logic [1:0]  ST_SHIFT = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;
    localparam logic [7:0]  PHASE_LAST = 8'(CLKDIV - 1);
    localparam logic [19:0] IDLE_LAST  = 20'(SCAN_PERIOD - 1);

    logic [1:0]  state_q, state_d;
    logic [19:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]  phase_cnt_q, phase_cnt_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic        half_q, half_d;         // second phase: LOAD phase B / SHIFT high phase
    logic [31:0] frame_q, frame_d;
    logic        sync1_q, sync2_q;
    logic        joy_clk_q, joy_clk_d;
    logic        joy_load_q, joy_load_d;
    logic [15:0] joystick1_q, joystick1_d;
    logic [15:0] joystick2_q, joystick2_d;
    logic        frame_done_q, frame_done_d;
    logic        phase_end_s;

    assign phase_end_s = (phase_cnt_q == PHASE_LAST);

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        bit_idx_d    = bit_idx_q;
        half_d       = half_q;
        frame_d      = frame_q;
        joystick1_d  = joystick1_q;
        joystick2_d  = joystick2_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_cnt_q == IDLE_LAST) begin
                    state_d     = ST_LOAD;
                    idle_cnt_d  = 20'd0;
                    phase_cnt_d = 8'd0;
                    half_d      = 1'b0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 20'd1;
                end
            end
            ST_LOAD: begin
                if (phase_end_s) begin
                    phase_cnt_d = 8'd0;
                    if (half_q) begin
                        state_d   = ST_SHIFT;
                        half_d    = 1'b0;
                        bit_idx_d = 5'd0;
                    end else begin
                        half_d = 1'b1;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (phase_end_s) begin
                    phase_cnt_d = 8'd0;
                    if (!half_q) begin
                        // chain output has settled for the whole low phase here
                        frame_d[bit_idx_q] = sync2_q;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (bit_idx_q == 5'd31) begin
                            state_d = ST_DONE;
                        end else begin
                            bit_idx_d = bit_idx_q + 5'd1;
                        end
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                idle_cnt_d = 20'd0;
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = 20'd0;
            end
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        if (state_d == ST_DONE) begin
            joystick1_d = ~frame_q[15:0];
            joystick2_d = ~frame_q[31:16];
        end else begin
            joystick1_d = joystick1_q;
            joystick2_d = joystick2_q;
        end
        joy_load_d   = !((state_d == ST_LOAD) && !half_d);
        joy_clk_d    = (state_d == ST_SHIFT) && half_d;
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idle_cnt_q   <= 20'd0;
            phase_cnt_q  <= 8'd0;
            bit_idx_q    <= 5'd0;
            half_q       <= 1'b0;
            frame_q      <= 32'd0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            joystick1_q  <= 16'd0;
            joystick2_q  <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            bit_idx_q    <= bit_idx_d;
            half_q       <= half_d;
            frame_q      <= frame_d;
            sync1_q      <= JOY_DATA;
            sync2_q      <= sync1_q;
            joy_clk_q    <= joy_clk_d;
            joy_load_q   <= joy_load_d;
            joystick1_q  <= joystick1_d;
            joystick2_q  <= joystick2_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign JOY_CLK    = joy_clk_q;
    assign JOY_LOAD   = joy_load_q;
    assign joystick1  = joystick1_q;
    assign joystick2  = joystick2_q;
    assign frame_done = frame_done_q;

endmodule
